async_operator_buf: RTL

- Parametrised successor to the dataflow req/ack operator node.
- Adds a `depth`-entry result FIFO between compute and output, so upstream keeps firing while consumers stall.
- Each output branch is served independently: every consumer receives every token exactly once, and a slow branch never causes a fast one to see duplicates.
- Operands are captured synchronously on `clk`; there is no edge-on-ack capture.
- Used for arf graph nodes with fan-out, and in place of reg chains when balancing paths.

---
 rtl/async_operator_buf.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/async_operator_buf.sv
// Dataflow operator node with a result FIFO and independently served fan-out branches.
// Operands are captured on clk via req/ack handshakes; each consumer sees every token exactly once.
module async_operator_buf #(
    parameter int    data_width  = 32,
    parameter int    input_size  = 2,
    parameter int    output_size = 1,
    parameter int    depth       = 4,
    parameter string op          = "add",
    parameter int    immediate   = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [input_size-1:0]            req_l,
    input  logic [input_size-1:0]            ack_l,
    input  logic [data_width*input_size-1:0] din,
    input  logic [output_size-1:0]           req_r,
    output logic [output_size-1:0]           ack_r,
    output logic [data_width-1:0]            dout,
    output logic [$clog2(depth+1)-1:0]       level
);

    localparam int PTR_W = $clog2(depth);
    localparam int LVL_W = $clog2(depth + 1);

    localparam int OP_PASS = 0;
    localparam int OP_ADDI = 1;
    localparam int OP_SUBI = 2;
    localparam int OP_MULI = 3;
    localparam int OP_ADD  = 4;
    localparam int OP_SUB  = 5;
    localparam int OP_MUL  = 6;

    // reg/in/out and any unrecognised name fall through to a plain pass of operand 0
    localparam int OP_SEL = (op == "addi") ? OP_ADDI :
                            (op == "subi") ? OP_SUBI :
                            (op == "muli") ? OP_MULI :
                            (op == "add")  ? OP_ADD  :
                            (op == "sub")  ? OP_SUB  :
                            (op == "mul")  ? OP_MUL  : OP_PASS;

    localparam logic [data_width-1:0] IMM = data_width'(immediate);

    genvar gi;

    logic [input_size-1:0]  has_q, has_d;
    logic [input_size-1:0]  req_l_q, req_l_d;
    logic [input_size-1:0]  accept;
    logic [data_width-1:0]  opnd [input_size];
    logic [data_width-1:0]  result;

    logic [output_size-1:0] served_q, served_d;
    logic [output_size-1:0] ack_r_q, ack_r_d;

    logic [data_width-1:0]  mem_q [depth];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;

    logic                   level_nz;
    logic                   fifo_full;
    logic                   pop;
    logic                   fire;

    assign level_nz  = (level_q != '0);
    assign fifo_full = (level_q == LVL_W'(depth));
    assign pop       = (&served_q) & level_nz;
    // A full FIFO still accepts a push when the head is leaving at the same edge
    assign fire      = (&has_q) & (~fifo_full | pop);

    // ---------------------------------------------------------------- input stage
    generate
        for (gi = 0; gi < input_size; gi++) begin : g_in
            logic [data_width-1:0] opnd_q;

            assign accept[gi] = ack_l[gi] & req_l_q[gi] & ~has_q[gi];
            assign has_d[gi]  = fire ? 1'b0 : (has_q[gi] | accept[gi]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opnd_q <= '0;
                end else if (accept[gi]) begin
                    opnd_q <= din[data_width*gi +: data_width];
                end
            end

            assign opnd[gi] = opnd_q;
        end
    endgenerate

    // Request tracks the empty slot, so it re-arms on the firing edge itself
    assign req_l_d = ~has_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            has_q   <= '0;
            req_l_q <= '0;
        end else begin
            has_q   <= has_d;
            req_l_q <= req_l_d;
        end
    end

    // ---------------------------------------------------------------- compute
    always_comb begin
        result = opnd[0];
        case (OP_SEL)
            OP_ADDI: result = opnd[0] + IMM;
            OP_SUBI: result = opnd[0] - IMM;
            OP_MULI: result = opnd[0] * IMM;
            OP_ADD: begin
                for (int i = 1; i < input_size; i++) begin
                    result = result + opnd[i];
                end
            end
            OP_SUB: begin
                for (int i = 1; i < input_size; i++) begin
                    result = result - opnd[i];
                end
            end
            OP_MUL: begin
                for (int i = 1; i < input_size; i++) begin
                    result = result * opnd[i];
                end
            end
            default: result = opnd[0];
        endcase
    end

    // ---------------------------------------------------------------- result FIFO
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (fire && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !fire) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < depth; k++) begin
                mem_q[k] <= '0;
            end
        end else if (fire) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // ---------------------------------------------------------------- output stage
    generate
        for (gi = 0; gi < output_size; gi++) begin : g_out
            // served_q blocks a second pulse for the same head; it only clears on pop
            assign ack_r_d[gi]  = level_nz & req_r[gi] & ~served_q[gi] & ~ack_r_q[gi];
            assign served_d[gi] = pop ? 1'b0 : (served_q[gi] | ack_r_d[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            served_q <= '0;
            ack_r_q  <= '0;
        end else begin
            served_q <= served_d;
            ack_r_q  <= ack_r_d;
        end
    end

    assign req_l = req_l_q;
    assign ack_r = ack_r_q;
    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule
